// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - two-button LED pattern sequencer with debounce, prescaler and mode FSM
module led_seq_ctrl #(
  parameter int TICK_DIV = 131072,
  parameter int DEB_LEN  = 10000
) (
  input  logic       PCLK,
  input  logic       RESET_N,
  input  logic       BTN_MODE_N,
  input  logic       BTN_HOLD_N,
  output logic [3:0] LD,
  output logic [1:0] MODE,
  output logic       PAUSED
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_LEN);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_LEN - 1);

  typedef enum logic [1:0] {
    COUNT = 2'b00,
    SHIFT = 2'b01,
    BLINK = 2'b10,
    OFF   = 2'b11
  } mode_t;

  // Bit 0 is the mode button, bit 1 the hold button.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    press;

  mode_t         state;
  logic [3:0]    count;
  logic [1:0]    pos;
  logic          dir;
  logic          phase;
  logic [PW-1:0] pre;
  logic          paused;
  logic          tick;

  assign btn_raw = {BTN_HOLD_N, BTN_MODE_N};

  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      stable     <= 2'b11;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Press fires on the edge where the stable level is about to fall.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      press[i] = stable[i] & ~sync2[i] & (deb_cnt[i] == DEB_MAX);
    end
  end

  assign tick = (pre == PRE_MAX);

  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= COUNT;
      count  <= 4'd0;
      pos    <= 2'd0;
      dir    <= 1'b0;
      phase  <= 1'b0;
      pre    <= '0;
      paused <= 1'b0;
    end else begin
      if (press[1]) begin
        paused <= ~paused;
      end
      if (press[0]) begin
        state <= mode_t'(state + 2'd1);
        count <= 4'd0;
        pos   <= 2'd0;
        dir   <= 1'b0;
        phase <= 1'b0;
        pre   <= '0;
      end else begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick && !paused) begin
          case (state)
            COUNT: count <= count + 4'd1;
            SHIFT: begin
              if (!dir) begin
                if (pos == 2'd3) begin
                  pos <= 2'd2;
                  dir <= 1'b1;
                end else begin
                  pos <= pos + 2'd1;
                end
              end else begin
                if (pos == 2'd0) begin
                  pos <= 2'd1;
                  dir <= 1'b0;
                end else begin
                  pos <= pos - 2'd1;
                end
              end
            end
            BLINK: phase <= ~phase;
            OFF:   ;
          endcase
        end
      end
    end
  end

  always_comb begin
    LD = 4'b1111;
    case (state)
      COUNT: LD = ~count;
      SHIFT: LD = ~(4'b0001 << pos);
      BLINK: LD = phase ? 4'b0000 : 4'b1111;
      OFF:   LD = 4'b1111;
    endcase
  end

  assign MODE   = state;
  assign PAUSED = paused;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed self-checking bench for led_seq_ctrl (TICK_DIV=4, DEB_LEN=3)
module tb_led_seq_ctrl;

  logic       PCLK;
  logic       RESET_N;
  logic       BTN_MODE_N;
  logic       BTN_HOLD_N;
  logic [3:0] LD;
  logic [1:0] MODE;
  logic       PAUSED;

  int total = 0;
  int bad   = 0;

  led_seq_ctrl #(.TICK_DIV(4), .DEB_LEN(3)) dut (
    .PCLK       (PCLK),
    .RESET_N    (RESET_N),
    .BTN_MODE_N (BTN_MODE_N),
    .BTN_HOLD_N (BTN_HOLD_N),
    .LD         (LD),
    .MODE       (MODE),
    .PAUSED     (PAUSED)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Each call advances n rising edges and returns at the following falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // A clean press registers on the fifth edge after the button goes low.
  task automatic press_mode();
    BTN_MODE_N = 1'b0;
    cycles(5);
    BTN_MODE_N = 1'b1;
  endtask

  task automatic press_hold();
    BTN_HOLD_N = 1'b0;
    cycles(5);
    BTN_HOLD_N = 1'b1;
  endtask

  logic [3:0] shift_seq [8];

  initial begin
    shift_seq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hB, 4'hD, 4'hE, 4'hD};
    RESET_N    = 1'b0;
    BTN_MODE_N = 1'b1;
    BTN_HOLD_N = 1'b1;
    #12;
    check("rst_ld", LD, 4'hF);
    check("rst_mode", MODE, 2'd0);
    check("rst_paused", PAUSED, 1'b0);

    @(negedge PCLK);
    RESET_N = 1'b1;
    cycles(3);
    check("count_e3", LD, 4'hF);
    cycles(1);
    check("count_e4", LD, 4'hE);
    cycles(16);
    check("count_e20", LD, 4'hA);
    cycles(44);
    check("count_wrap", LD, 4'hF);

    BTN_MODE_N = 1'b0;
    cycles(2);
    BTN_MODE_N = 1'b1;
    cycles(10);
    check("glitch_mode", MODE, 2'd0);

    BTN_MODE_N = 1'b0;
    cycles(4);
    check("press_e4", MODE, 2'd0);
    cycles(1);
    check("press_e5", MODE, 2'd1);
    check("shift_0", LD, shift_seq[0]);
    for (int i = 1; i < 8; i++) begin
      cycles(4);
      check($sformatf("shift_%0d", i), LD, shift_seq[i]);
    end
    cycles(67);
    check("long_once", MODE, 2'd1);
    BTN_MODE_N = 1'b1;
    cycles(10);
    check("release_none", MODE, 2'd1);

    press_mode();
    check("to_blink", MODE, 2'd2);
    check("blink_ld", LD, 4'hF);
    cycles(6);
    press_mode();
    check("to_off", MODE, 2'd3);
    check("off_ld", LD, 4'hF);
    cycles(6);
    press_mode();
    check("to_count", MODE, 2'd0);
    check("count_rst_ld", LD, 4'hF);

    cycles(15);
    press_hold();
    check("pause_on", PAUSED, 1'b1);
    check("pause_ld", LD, 4'hA);
    for (int i = 0; i < 4; i++) begin
      cycles(10);
      check($sformatf("frozen_%0d", i), LD, 4'hA);
    end
    check("mode_kept", MODE, 2'd0);
    cycles(2);
    press_hold();
    check("pause_off", PAUSED, 1'b0);
    check("resume_ld", LD, 4'hA);
    cycles(1);
    check("resume_6", LD, 4'h9);
    cycles(4);
    check("resume_7", LD, 4'h8);

    cycles(3);
    press_mode();
    check("coll_mode", MODE, 2'd1);
    check("coll_ld", LD, 4'hE);
    cycles(3);
    check("coll_e3", LD, 4'hE);
    cycles(1);
    check("coll_e4", LD, 4'hD);

    cycles(2);
    BTN_MODE_N = 1'b0;
    BTN_HOLD_N = 1'b0;
    cycles(5);
    BTN_MODE_N = 1'b1;
    BTN_HOLD_N = 1'b1;
    check("both_mode", MODE, 2'd2);
    check("both_paused", PAUSED, 1'b1);
    cycles(10);
    check("blink_frozen", LD, 4'hF);
    press_hold();
    check("blink_run", PAUSED, 1'b0);
    cycles(1);
    check("blink_on", LD, 4'h0);
    cycles(3);
    press_hold();
    check("blink_pause", PAUSED, 1'b1);
    check("blink_pause_ld", LD, 4'h0);
    cycles(8);
    check("blink_hold_ld", LD, 4'h0);

    #2 RESET_N = 1'b0;
    #1;
    check("async_ld", LD, 4'hF);
    check("async_mode", MODE, 2'd0);
    check("async_paused", PAUSED, 1'b0);

    cycles(2);
    RESET_N = 1'b1;
    BTN_MODE_N = 1'b0;
    cycles(3);
    #2 RESET_N = 1'b0;
    BTN_MODE_N = 1'b1;
    cycles(2);
    RESET_N = 1'b1;
    cycles(10);
    check("abandon_mode", MODE, 2'd0);
    check("abandon_ld", LD, 4'hD);
    check("abandon_paused", PAUSED, 1'b0);

    #2 RESET_N = 1'b0;
    BTN_MODE_N = 1'b0;
    cycles(2);
    RESET_N = 1'b1;
    cycles(4);
    check("held_e4", MODE, 2'd0);
    cycles(1);
    check("held_e5", MODE, 2'd1);
    BTN_MODE_N = 1'b1;
    cycles(6);
    check("held_once", MODE, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 131072: PCLK cycles per pattern step (range 2..2^20).
REQ-002 The block SHALL have parameter DEB_LEN, default 10000: consecutive PCLK cycles a button level must persist to be accepted (range 2..2^16).
REQ-003 The block SHALL have port PCLK, input, 1 bit: single clock; all state is on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port BTN_MODE_N, input, 1 bit: asynchronous mode button, active-low.
REQ-006 The block SHALL have port BTN_HOLD_N, input, 1 bit: asynchronous pause button, active-low.
REQ-007 The block SHALL have port LD, output, 4 bits: LED drive, active-low (0 = lit).
REQ-008 The block SHALL have port MODE, output, 2 bits: current mode (00 COUNT, 01 SHIFT, 10 BLINK, 11 OFF).
REQ-009 The block SHALL have port PAUSED, output, 1 bit: 1 while pattern stepping is frozen.

Function
REQ-010 Each button input SHALL pass through its own 2-flop synchroniser; both flops reset to 1 (released).
REQ-011 Per button: debounce counter clears whenever synced level equals the stable level, else increments; when it reaches DEB_LEN-1, stable level takes synced level and counter clears.
REQ-012 A press event SHALL be a one-cycle pulse on a stable-level 1->0 transition; release and holding SHALL generate no event.
REQ-013 The prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is asserted while prescaler == TICK_DIV-1 and is free-running regardless of PAUSED.
REQ-014 The mode FSM SHALL advance COUNT->SHIFT->BLINK->OFF->COUNT, one step per mode press event.
REQ-015 On a mode press, the pattern state (count=0, pos=0, dir=up, phase=0) SHALL be reset and the prescaler cleared to 0 on the same edge.
REQ-016 A tick SHALL advance the pattern only when PAUSED=0 and no mode press occurs in the same cycle; a mode press SHALL win and discard the tick.
REQ-017 COUNT: the 4-bit count SHALL increment per tick, wrap 15->0, and drive LD = ~count.
REQ-018 SHIFT: pos SHALL bounce through 0,1,2,3,2,1,0,1,... (at pos 3 going up, go to 2 and set dir down; at pos 0 going down, go to 1 and set dir up); LD = ~(1<<pos).
REQ-019 BLINK: phase SHALL toggle per tick; LD = 0000 when phase=1, 1111 when phase=0.
REQ-020 OFF: LD SHALL be 1111; ticks are ignored.
REQ-021 A hold press event SHALL toggle PAUSED; mode presses SHALL not alter PAUSED. Simultaneous mode and hold events SHALL both take effect in the same cycle.
REQ-022 LD, MODE and PAUSED SHALL be decoded combinationally from registered state, with no added latency beyond REQ-017..020.

Reset
REQ-023 RESET_N low SHALL immediately, without a clock, force MODE=00, PAUSED=0, count=0, pos=0, dir=up, phase=0, prescaler=0, debounce counters=0, synchronisers and stable levels=1, giving LD=1111.
REQ-024 A button held low across reset deassertion SHALL register as a press once debounced after reset.
REQ-025 Reset asserted mid-pattern or mid-debounce SHALL abandon all in-progress state, with no residual event.

Verification (TICK_DIV=4, DEB_LEN=3)
REQ-026 Release reset, buttons high -> LD=1111; after 4 edges LD=1110; after 64 edges LD=1111 (wrap).
REQ-027 BTN_MODE_N low for 2 cycles then high -> MODE stays 00; low for 100 cycles -> MODE=01 exactly once, within 6 edges of assertion.
REQ-028 In SHIFT, successive ticks -> LD 1110,1101,1011,0111,1011,1101,1110,1101.
REQ-029 Hold press in COUNT at count=5 -> PAUSED=1 and LD=1010 constant for 40 cycles; second press -> PAUSED=0 and stepping resumes from 5.
REQ-030 Mode press debounced on the same edge as a tick -> MODE advances, pattern at its reset value, prescaler 0, next step after 4 edges.
REQ-031 Assert RESET_N low asynchronously between edges in BLINK with PAUSED=1 -> LD=1111, MODE=00, PAUSED=0 before the next edge.
